// File: rtl/crc16_frame_seq.sv
// -----------------------------------------------------------------------------
// crc16_frame_seq
// Frame sequencer for the byte-wide CRC-16 datapath (x^16 + x^12 + x^5 + 1,
// MSB-first). Bytes arriving on the s_* valid/ready port are forwarded
// unchanged on the m_* port. The CRC is chained across every byte of a frame.
// After the byte flagged with s_last, the 2-byte CRC is appended, high byte
// first.
//
// Optional feature: define CRC16_CHECK_EN to add the receive-side check ports
// chk_valid and chk_ok.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   s_valid/s_ready       input byte handshake
//   s_data, s_last        input byte; s_last marks the final data byte
//   m_valid/m_ready       output byte handshake (single output register)
//   m_data, m_last        output byte; m_last is high on the CRC low byte only
//   byte_cnt              data bytes accepted in the current/most recent frame
//   len_err               sticky: frame exceeded MAX_LEN
//   busy                  first accepted byte .. CRC low byte accepted
//   chk_valid, chk_ok     (CRC16_CHECK_EN) residue check, one pulse per frame
// -----------------------------------------------------------------------------
module crc16_frame_seq #(
    parameter logic [15:0] INIT    = 16'h0000,
    parameter logic [15:0] POLY    = 16'h1021,
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             len_err,
    output logic             busy
`ifdef CRC16_CHECK_EN
    ,
    output logic             chk_valid,
    output logic             chk_ok
`endif
);

    typedef enum logic [1:0] {ST_DATA, ST_CRC_HI, ST_CRC_LO} state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [7:0]  data_in);
        logic [15:0] c;
        logic [7:0]  d;
        c = crc_in;
        d = data_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15] ^ d[7]) c = (c << 1) ^ POLY;
            else              c = c << 1;
            d = d << 1;
        end
        return c;
    endfunction

    state_e           state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic             in_frame_q, in_frame_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             len_err_q, len_err_d;
    logic             busy_q, busy_d;

    logic             slot_free;
    logic             accept;
    logic [15:0]      crc_base;
    logic [15:0]      crc_next;

    always_comb begin
        slot_free  = !m_valid_q || m_ready;
        s_ready    = (state_q == ST_DATA) && slot_free;
        accept     = s_valid && s_ready;
        // The first byte of a frame starts from INIT rather than the stale CRC.
        crc_base   = in_frame_q ? crc_q : INIT;
        crc_next   = crc_step(crc_base, s_data);

        state_d    = state_q;
        crc_d      = crc_q;
        in_frame_d = in_frame_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        byte_cnt_d = byte_cnt_q;
        len_err_d  = len_err_q;
        busy_d     = busy_q;

        // Clear on the CRC low byte leaving; a new frame accepted in the same
        // cycle sets it again below.
        if (m_valid_q && m_ready && m_last_q) busy_d = 1'b0;

        unique case (state_q)
            ST_DATA: begin
                if (accept) begin
                    m_data_d   = s_data;
                    m_valid_d  = 1'b1;
                    m_last_d   = 1'b0;
                    crc_d      = crc_next;
                    in_frame_d = 1'b1;
                    busy_d     = 1'b1;
                    if (!in_frame_q) begin
                        byte_cnt_d = CNT_W'(1);
                        len_err_d  = 1'b0;
                    end else if (byte_cnt_q == MAX_CNT) begin
                        len_err_d  = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                    if (s_last) state_d = ST_CRC_HI;
                end else if (slot_free) begin
                    m_valid_d = 1'b0;
                end
            end
            ST_CRC_HI: begin
                if (slot_free) begin
                    m_data_d  = crc_q[15:8];
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = ST_CRC_LO;
                end
            end
            ST_CRC_LO: begin
                if (slot_free) begin
                    m_data_d   = crc_q[7:0];
                    m_valid_d  = 1'b1;
                    m_last_d   = 1'b1;
                    in_frame_d = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DATA;
            crc_q      <= INIT;
            in_frame_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            byte_cnt_q <= '0;
            len_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            in_frame_q <= in_frame_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            byte_cnt_q <= byte_cnt_d;
            len_err_q  <= len_err_d;
            busy_q     <= busy_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign byte_cnt = byte_cnt_q;
    assign len_err  = len_err_q;
    assign busy     = busy_q;

`ifdef CRC16_CHECK_EN
    // A frame carrying its own CRC leaves a zero residue after its last byte.
    logic chk_valid_q, chk_valid_d;
    logic chk_ok_q, chk_ok_d;

    always_comb begin
        chk_valid_d = accept && s_last;
        chk_ok_d    = chk_ok_q;
        if (chk_valid_d) chk_ok_d = (crc_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
        end else begin
            chk_valid_q <= chk_valid_d;
            chk_ok_q    <= chk_ok_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign chk_ok    = chk_ok_q;
`endif

endmodule
